// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit and its next-PC helper.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int unsigned OP_HI  = 31;
  localparam int unsigned OP_LO  = 26;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;
  localparam int unsigned JT_HI  = 25;
  localparam int unsigned JT_LO  = 0;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read handshake plus decoder-facing instruction handoff.
interface instr_fetch_unit_if #(
  parameter int unsigned AW = 32
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_valid;
  logic [31:0]   imem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic [5:0]    Op;
  logic          jump;
  logic          Branch;
  logic          Zero;
  logic [31:0]   retire_count;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, Op, retire_count,
    input  imem_valid, imem_rdata, instr_ready, jump, Branch, Zero
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, Op, retire_count,
    output imem_valid, imem_rdata, instr_ready, jump, Branch, Zero
  );
endinterface

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Combinational next-PC selection: jump over taken branch over sequential.
module pc_next_calc
  import if_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic [AW-1:0]    instr_pc_i,
  input  logic [JT_HI:0]   instr_idx_i,
  input  logic             jump_i,
  input  logic             branch_i,
  input  logic             zero_i,
  output logic [AW-1:0]    next_pc_o
);

  logic [AW-1:0] pc4;
  logic [AW-1:0] br_off;
  logic [AW-1:0] br_target;
  logic [AW-1:0] jmp_target;

  assign pc4        = instr_pc_i + AW'(4);
  assign br_off     = {{(AW-18){instr_idx_i[IMM_HI]}}, instr_idx_i[IMM_HI:IMM_LO], 2'b00};
  assign br_target  = pc4 + br_off;
  assign jmp_target = {pc4[AW-1:28], instr_idx_i[JT_HI:JT_LO], 2'b00};

  always_comb begin
    next_pc_o = pc4;
    if (jump_i) begin
      next_pc_o = jmp_target;
    end else if (branch_i && zero_i) begin
      next_pc_o = br_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-issue fetch: FETCH issues one read, WAIT takes the reply, HOLD offers it downstream.
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned     AW       = 32,
  parameter logic [AW-1:0]   RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic [31:0]   retire_q, retire_d;
  logic          started_q;
  logic [AW-1:0] next_pc;

  pc_next_calc #(.AW(AW)) u_pc_next_calc (
    .instr_pc_i  (instr_pc_q),
    .instr_idx_i (instr_q[JT_HI:0]),
    .jump_i      (bus.jump),
    .branch_i    (bus.Branch),
    .zero_i      (bus.Zero),
    .next_pc_o   (next_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    retire_d   = retire_q;
    unique case (state_q)
      FETCH: if (started_q) state_d = WAIT;
      WAIT: begin
        if (bus.imem_valid) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = pc_q;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          pc_d     = next_pc;
          retire_d = retire_q + 32'd1;
          state_d  = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // started_q holds off the first request until the cycle after reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      retire_q   <= '0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      retire_q   <= retire_d;
      started_q  <= 1'b1;
    end
  end

  assign bus.imem_req     = (state_q == FETCH) && started_q;
  assign bus.imem_addr    = bus.imem_req ? pc_q : '0;
  assign bus.instr_valid  = (state_q == HOLD);
  assign bus.instr        = instr_q;
  assign bus.instr_pc     = instr_pc_q;
  assign bus.Op           = instr_q[OP_HI:OP_LO];
  assign bus.retire_count = retire_q;

endmodule
